// File: rtl/color_sense_pkg.sv
// Shared codes and classification helpers for the colour-sensor controller.
// Optional CLEAR channel is enabled by defining CS_CLEAR_CH_EN.
package color_sense_pkg;

    typedef enum logic [1:0] {
        FLT_RED   = 2'b00,
        FLT_BLUE  = 2'b01,
        FLT_CLEAR = 2'b10,
        FLT_GREEN = 2'b11
    } filter_t;

    typedef enum logic [2:0] {
        COL_NONE  = 3'd0,
        COL_RED   = 3'd1,
        COL_GREEN = 3'd2,
        COL_BLUE  = 3'd3
    } color_t;

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, CLASSIFY} cs_state_t;

    // Measurement order: GREEN, RED, BLUE, then CLEAR when that channel exists.
    function automatic filter_t next_filter(input filter_t cur);
        case (cur)
            FLT_GREEN: return FLT_RED;
            FLT_RED:   return FLT_BLUE;
            default:   return FLT_CLEAR;
        endcase
    endfunction

    // Ties resolve to RED first, then BLUE over GREEN.
    function automatic color_t classify(input logic [31:0] r, input logic [31:0] g,
                                        input logic [31:0] b, input logic [31:0] min_cnt);
        if (r < min_cnt && g < min_cnt && b < min_cnt) return COL_NONE;
        if (r >= g && r >= b) return COL_RED;
        if (g > b) return COL_GREEN;
        return COL_BLUE;
    endfunction

endpackage

// File: rtl/color_sense_ctrl_if.sv
// Sensor-pin and result bundle between the colour-sense controller and its consumer.
// Carries clear_cnt only when CS_CLEAR_CH_EN is defined.
interface color_sense_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic             cs_out;
    logic [1:0]       filter;
    logic [2:0]       color;
    logic             frame_done;
    logic             busy;
    logic [CNT_W-1:0] red_cnt;
    logic [CNT_W-1:0] green_cnt;
    logic [CNT_W-1:0] blue_cnt;
`ifdef CS_CLEAR_CH_EN
    logic [CNT_W-1:0] clear_cnt;

    modport master (output en, cs_out,
                    input  filter, color, frame_done, busy, red_cnt, green_cnt, blue_cnt, clear_cnt);
    modport slave  (input  en, cs_out,
                    output filter, color, frame_done, busy, red_cnt, green_cnt, blue_cnt, clear_cnt);
`else
    modport master (output en, cs_out,
                    input  filter, color, frame_done, busy, red_cnt, green_cnt, blue_cnt);
    modport slave  (input  en, cs_out,
                    output filter, color, frame_done, busy, red_cnt, green_cnt, blue_cnt);
`endif
endinterface

// File: rtl/cs_edge_sync.sv
// Synchronises the asynchronous sensor output and emits a one-cycle pulse per rising edge.
module cs_edge_sync #(
    parameter int unsigned SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);
    logic [SYNC-1:0] sync_q;
    logic            last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], din};
            last_q <= sync_q[SYNC-1];
        end
    end

    assign pulse = sync_q[SYNC-1] & ~last_q;
endmodule

// File: rtl/color_sense_ctrl.sv
// Gated per-channel frequency counter and confirmed colour classifier for a TCS3200-class sensor.
// Defining CS_CLEAR_CH_EN adds a CLEAR channel that vetoes classification in dim light.
module color_sense_ctrl
    import color_sense_pkg::*;
#(
    parameter int unsigned GATE_CYC   = 500,
    parameter int unsigned SETTLE_CYC = 20,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MIN_CNT    = 8,
    parameter int unsigned CONFIRM_N  = 2
) (
    input logic               clk_1MHz,
    input logic               rst_n,
    color_sense_ctrl_if.slave bus
);
    localparam int unsigned      TMR_W     = $clog2(GATE_CYC + SETTLE_CYC + 1);
    localparam int unsigned      MATCH_W   = $clog2(CONFIRM_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);
    localparam cs_state_t        FIRST_ST  = (SETTLE_CYC == 0) ? GATE : SETTLE;
    localparam logic [TMR_W-1:0] FIRST_LD  = (SETTLE_CYC == 0) ? GATE_LD : SETTLE_LD;

    cs_state_t          state, state_n;
    logic [TMR_W-1:0]   timer, timer_n;
    filter_t            filter_q, filter_n;
    logic [CNT_W-1:0]   work, work_n, work_inc;
    logic [CNT_W-1:0]   red_q, green_q, blue_q;
    color_t             prev_cand, cand, color_q;
    logic [MATCH_W-1:0] match, match_n;
    logic               edge_pulse;
    logic               latch_en;
    logic               last_ch;

    cs_edge_sync #(.SYNC(2)) u_sync (
        .clk   (clk_1MHz),
        .rst_n (rst_n),
        .din   (bus.cs_out),
        .pulse (edge_pulse)
    );

    assign work_inc = (edge_pulse && work != CNT_MAX) ? work + 1'b1 : work;

`ifdef CS_CLEAR_CH_EN
    logic [CNT_W-1:0] clear_q;
    assign last_ch       = (filter_q == FLT_CLEAR);
    assign bus.clear_cnt = clear_q;
`else
    assign last_ch = (filter_q == FLT_BLUE);
`endif

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        filter_n = filter_q;
        work_n   = work;
        latch_en = 1'b0;
        case (state)
            IDLE: begin
                filter_n = FLT_CLEAR;
                work_n   = '0;
                if (bus.en) begin
                    state_n  = FIRST_ST;
                    timer_n  = FIRST_LD;
                    filter_n = FLT_GREEN;
                end
            end
            SETTLE: begin
                timer_n = timer - 1'b1;
                if (timer == '0) begin
                    state_n = GATE;
                    timer_n = GATE_LD;
                end
            end
            GATE: begin
                timer_n = timer - 1'b1;
                work_n  = work_inc;
                if (timer == '0) begin
                    latch_en = 1'b1;
                    work_n   = '0;
                    filter_n = next_filter(filter_q);
                    if (last_ch) begin
                        state_n  = CLASSIFY;
                        filter_n = FLT_CLEAR;
                    end else begin
                        state_n = FIRST_ST;
                        timer_n = FIRST_LD;
                    end
                end
            end
            CLASSIFY: begin
                if (bus.en) begin
                    state_n  = FIRST_ST;
                    timer_n  = FIRST_LD;
                    filter_n = FLT_GREEN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Abort overrides everything, including a latch on the final gate cycle.
        if (!bus.en && (state == SETTLE || state == GATE)) begin
            state_n  = IDLE;
            filter_n = FLT_CLEAR;
            work_n   = '0;
            latch_en = 1'b0;
        end
    end

    always_comb begin
        cand = classify(32'(red_q), 32'(green_q), 32'(blue_q), MIN_CNT);
`ifdef CS_CLEAR_CH_EN
        if (32'(clear_q) < MIN_CNT * 4) cand = COL_NONE;
`endif
        if (cand == prev_cand)
            match_n = (match == MATCH_W'(CONFIRM_N)) ? match : match + 1'b1;
        else
            match_n = MATCH_W'(1);
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            filter_q  <= FLT_CLEAR;
            work      <= '0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
`ifdef CS_CLEAR_CH_EN
            clear_q   <= '0;
`endif
            prev_cand <= COL_NONE;
            match     <= '0;
            color_q   <= COL_NONE;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            filter_q <= filter_n;
            work     <= work_n;
            if (latch_en) begin
                case (filter_q)
                    FLT_GREEN: green_q <= work_inc;
                    FLT_RED:   red_q   <= work_inc;
                    FLT_BLUE:  blue_q  <= work_inc;
`ifdef CS_CLEAR_CH_EN
                    FLT_CLEAR: clear_q <= work_inc;
`endif
                    default: ;
                endcase
            end
            if (state == CLASSIFY) begin
                prev_cand <= cand;
                match     <= match_n;
                if (match_n == MATCH_W'(CONFIRM_N)) color_q <= cand;
            end
        end
    end

    assign bus.filter     = filter_q;
    assign bus.color      = color_q;
    assign bus.frame_done = (state == CLASSIFY);
    assign bus.busy       = (state != IDLE);
    assign bus.red_cnt    = red_q;
    assign bus.green_cnt  = green_q;
    assign bus.blue_cnt   = blue_q;
endmodule

// File: tb/tb_color_sense_ctrl.sv
// Directed bench for color_sense_ctrl: timing, classification, confirmation, saturation, abort, reset.
module tb_color_sense_ctrl;
    localparam int unsigned GATE = 100;
    localparam int unsigned SETL = 4;
`ifdef CS_CLEAR_CH_EN
    localparam int unsigned NCH = 4;
`else
    localparam int unsigned NCH = 3;
`endif
    localparam int unsigned LAT = NCH * (SETL + GATE) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // cs_out period in clk cycles, indexed by filter code (RED=0 BLUE=1 CLEAR=2 GREEN=3); 0 = held low
    int unsigned per [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    color_sense_ctrl_if #(.CNT_W(16)) bus ();
    color_sense_ctrl_if #(.CNT_W(4))  sbus ();

    color_sense_ctrl #(.GATE_CYC(GATE), .SETTLE_CYC(SETL), .CNT_W(16), .MIN_CNT(8), .CONFIRM_N(2))
        dut (.clk_1MHz(clk), .rst_n(rst_n), .bus(bus));

    color_sense_ctrl #(.GATE_CYC(GATE), .SETTLE_CYC(SETL), .CNT_W(4), .MIN_CNT(8), .CONFIRM_N(2))
        dut_sat (.clk_1MHz(clk), .rst_n(rst_n), .bus(sbus));

    initial begin
        int unsigned phase;
        int unsigned p;
        logic [1:0]  last_flt;
        phase = 0;
        last_flt = 2'b10;
        bus.cs_out = 1'b0;
        forever begin
            @(negedge clk);
            p = per[bus.filter];
            if (bus.filter != last_flt) phase = 0;
            else if (p != 0) phase = (phase + 1) % p;
            last_flt = bus.filter;
            bus.cs_out = (p != 0 && phase < p / 2);
        end
    end

    initial begin
        sbus.cs_out = 1'b0;
        forever @(negedge clk) sbus.cs_out = ~sbus.cs_out;
    end

    task automatic wait_frame(output int unsigned lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.frame_done && lat < 3000);
        checks++;
        if (!bus.frame_done) begin
            failures++;
            $display("FAIL frame_timeout: frame_done=%0b after %0d cycles, required 1", bus.frame_done, lat);
        end
    endtask

    task automatic test_reset();
        bus.en = 1'b0;
        sbus.en = 1'b0;
        rst_n = 1'b0;
        #23;
        checks++;
        if (bus.filter !== 2'b10) begin failures++; $display("FAIL reset_filter: got %b want 10", bus.filter); end
        checks++;
        if (bus.color !== 3'd0) begin failures++; $display("FAIL reset_color: got %0d want 0", bus.color); end
        checks++;
        if ({bus.red_cnt, bus.green_cnt, bus.blue_cnt} !== 48'd0) begin
            failures++;
            $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", bus.red_cnt, bus.green_cnt, bus.blue_cnt);
        end
        checks++;
        if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: frame_done=%b busy=%b want 0 0", bus.frame_done, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int unsigned lat;
        per[0] = 5; per[3] = 10; per[1] = 20;
`ifdef CS_CLEAR_CH_EN
        per[2] = 2;
`else
        per[2] = 40;
`endif
        @(negedge clk);
        bus.en = 1'b1;
        wait_frame(lat);
        checks++;
        if (lat != LAT) begin failures++; $display("FAIL first_latency: got %0d want %0d", lat, LAT); end
        checks++;
        if ({bus.red_cnt, bus.green_cnt, bus.blue_cnt} !== {16'd20, 16'd10, 16'd5}) begin
            failures++;
            $display("FAIL basic_counts: got %0d/%0d/%0d want 20/10/5", bus.red_cnt, bus.green_cnt, bus.blue_cnt);
        end
`ifdef CS_CLEAR_CH_EN
        checks++;
        if (bus.clear_cnt !== 16'd50) begin failures++; $display("FAIL basic_clear: got %0d want 50", bus.clear_cnt); end
`endif
        @(posedge clk); #1;
        checks++;
        if (bus.color !== 3'd0) begin failures++; $display("FAIL confirm_1st: got %0d want 0", bus.color); end
        wait_frame(lat);
        checks++;
        if (lat != LAT - 1) begin failures++; $display("FAIL frame_period: got %0d want %0d", lat, LAT - 1); end
        @(posedge clk); #1;
        checks++;
        if (bus.color !== 3'd1) begin failures++; $display("FAIL confirm_red: got %0d want 1", bus.color); end
    endtask

    task automatic test_dominance();
        int unsigned lat;
        per[0] = 20; per[3] = 4; per[1] = 10;
        wait_frame(lat);
        checks++;
        if ({bus.red_cnt, bus.green_cnt, bus.blue_cnt} !== {16'd5, 16'd25, 16'd10}) begin
            failures++;
            $display("FAIL green_counts: got %0d/%0d/%0d want 5/25/10", bus.red_cnt, bus.green_cnt, bus.blue_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.color !== 3'd1) begin failures++; $display("FAIL green_hold: got %0d want 1", bus.color); end
        wait_frame(lat);
        @(posedge clk); #1;
        checks++;
        if (bus.color !== 3'd2) begin failures++; $display("FAIL green_commit: got %0d want 2", bus.color); end
        per[0] = 20; per[3] = 10; per[1] = 4;
        wait_frame(lat);
        checks++;
        if ({bus.red_cnt, bus.green_cnt, bus.blue_cnt} !== {16'd5, 16'd10, 16'd25}) begin
            failures++;
            $display("FAIL blue_counts: got %0d/%0d/%0d want 5/10/25", bus.red_cnt, bus.green_cnt, bus.blue_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.color !== 3'd2) begin failures++; $display("FAIL blue_no_glitch: got %0d want 2", bus.color); end
        wait_frame(lat);
        @(posedge clk); #1;
        checks++;
        if (bus.color !== 3'd3) begin failures++; $display("FAIL blue_commit: got %0d want 3", bus.color); end
    endtask

    task automatic test_dark_and_tie();
        int unsigned lat;
        per[0] = 0; per[3] = 0; per[1] = 0;
        wait_frame(lat);
        checks++;
        if ({bus.red_cnt, bus.green_cnt, bus.blue_cnt} !== 48'd0) begin
            failures++;
            $display("FAIL dark_counts: got %0d/%0d/%0d want 0/0/0", bus.red_cnt, bus.green_cnt, bus.blue_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.color !== 3'd3) begin failures++; $display("FAIL dark_hold: got %0d want 3", bus.color); end
        wait_frame(lat);
        @(posedge clk); #1;
        checks++;
        if (bus.color !== 3'd0) begin failures++; $display("FAIL dark_none: got %0d want 0", bus.color); end
        per[0] = 5; per[3] = 5; per[1] = 5;
        wait_frame(lat);
        checks++;
        if ({bus.red_cnt, bus.green_cnt, bus.blue_cnt} !== {16'd20, 16'd20, 16'd20}) begin
            failures++;
            $display("FAIL tie_counts: got %0d/%0d/%0d want 20/20/20", bus.red_cnt, bus.green_cnt, bus.blue_cnt);
        end
        wait_frame(lat);
        @(posedge clk); #1;
        checks++;
        if (bus.color !== 3'd1) begin failures++; $display("FAIL tie_red: got %0d want 1", bus.color); end
    endtask

    task automatic test_saturate();
        int unsigned n;
        @(negedge clk);
        sbus.en = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!sbus.frame_done && n < 3000);
        checks++;
        if (!sbus.frame_done) begin failures++; $display("FAIL sat_timeout: frame_done=0 after %0d cycles, required 1", n); end
        checks++;
        if ({sbus.red_cnt, sbus.green_cnt, sbus.blue_cnt} !== {4'd15, 4'd15, 4'd15}) begin
            failures++;
            $display("FAIL sat_counts: got %0d/%0d/%0d want 15/15/15", sbus.red_cnt, sbus.green_cnt, sbus.blue_cnt);
        end
        @(negedge clk);
        sbus.en = 1'b0;
    endtask

    task automatic test_abort();
        int unsigned n;
        bit          seen_done;
        n = 0;
        while (bus.filter !== 2'b11 && n < 1000) begin @(posedge clk); #1; n++; end
        while (bus.filter !== 2'b00 && n < 1000) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 1000) begin failures++; $display("FAIL abort_reach_red: filter=%b after %0d cycles, required 00", bus.filter, n); end
        repeat (SETL + 10) @(posedge clk);
        @(negedge clk);
        bus.en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.filter !== 2'b10) begin
            failures++;
            $display("FAIL abort_idle: busy=%b filter=%b want 0 10", bus.busy, bus.filter);
        end
        seen_done = bus.frame_done;
        repeat (5) begin @(posedge clk); #1; seen_done |= bus.frame_done; end
        checks++;
        if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done: frame_done seen=%b want 0", seen_done); end
        checks++;
        if ({bus.red_cnt, bus.green_cnt, bus.blue_cnt} !== {16'd20, 16'd20, 16'd20}) begin
            failures++;
            $display("FAIL abort_held: got %0d/%0d/%0d want 20/20/20", bus.red_cnt, bus.green_cnt, bus.blue_cnt);
        end
        @(negedge clk);
        bus.en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.filter !== 2'b11 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_green: filter=%b busy=%b want 11 1", bus.filter, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned lat;
        repeat (SETL + 20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.filter !== 2'b10 || bus.color !== 3'd0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_flags: filter=%b color=%0d busy=%b done=%b want 10 0 0 0",
                     bus.filter, bus.color, bus.busy, bus.frame_done);
        end
        checks++;
        if ({bus.red_cnt, bus.green_cnt, bus.blue_cnt} !== 48'd0) begin
            failures++;
            $display("FAIL midreset_counts: got %0d/%0d/%0d want 0/0/0", bus.red_cnt, bus.green_cnt, bus.blue_cnt);
        end
        per[0] = 5; per[3] = 10; per[1] = 20; per[2] = 40;
        @(negedge clk);
        rst_n = 1'b1;
        wait_frame(lat);
        checks++;
        if (lat != LAT) begin failures++; $display("FAIL post_reset_latency: got %0d want %0d", lat, LAT); end
        wait_frame(lat);
        @(posedge clk); #1;
`ifdef CS_CLEAR_CH_EN
        checks++;
        if (bus.clear_cnt !== 16'd2) begin failures++; $display("FAIL dim_clear: got %0d want 2", bus.clear_cnt); end
        checks++;
        if (bus.color !== 3'd0) begin failures++; $display("FAIL dim_none: got %0d want 0", bus.color); end
`else
        checks++;
        if (bus.color !== 3'd1) begin failures++; $display("FAIL post_reset_red: got %0d want 1", bus.color); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dominance();
        test_dark_and_tie();
        test_saturate();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
